// File: rtl/clock_pkg.sv
// clock_pkg: state/field encodings, field limits and calendar helpers
// shared by clock_set_core and its testbench.
package clock_pkg;

    // Field codes double as the set-mode state encoding, so field_sel is the state register.
    localparam logic [2:0] FIELD_YEAR  = 3'd0;
    localparam logic [2:0] FIELD_MONTH = 3'd1;
    localparam logic [2:0] FIELD_DAY   = 3'd2;
    localparam logic [2:0] FIELD_HOUR  = 3'd3;
    localparam logic [2:0] FIELD_MIN   = 3'd4;
    localparam logic [2:0] FIELD_SEC   = 3'd5;
    localparam logic [2:0] RUN_SEL     = 3'd7;

    localparam logic [7:0] SEC_MAX   = 8'd59;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MONTH_MAX = 8'd12;
    localparam logic [7:0] YEAR_MAX  = 8'd99;

    typedef enum logic [2:0] {
        S_YEAR  = FIELD_YEAR,
        S_MONTH = FIELD_MONTH,
        S_DAY   = FIELD_DAY,
        S_HOUR  = FIELD_HOUR,
        S_MIN   = FIELD_MIN,
        S_SEC   = FIELD_SEC,
        RUN     = RUN_SEL
    } state_t;

    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } cal_t;

    // Years are 2000..2099, so year%4==0 is the complete leap rule here.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            8'd2:                    return (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 return 8'd31;
        endcase
    endfunction

    // One step up or down inside [lo, hi], wrapping at either end.
    function automatic logic [7:0] step_wrap(input logic [7:0] value, lo, hi, input logic up);
        if (up) return (value >= hi) ? lo : value + 8'd1;
        else    return (value <= lo) ? hi : value - 8'd1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: accepts a new switch level only after the raw input has
// disagreed with it for DEBOUNCE_CYC consecutive cycles, and emits a
// one-cycle press one cycle after a 0->1 acceptance.
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] cnt;
    logic          level_d;

    // Disagreement counter, accepted level and registered rising-edge detect.
    always_ff @(posedge clk) begin
        // NOTE: every state register in a clocked block uses <= so all flops update from pre-edge values.
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            if (raw != level) begin
                if (cnt == CNT_LAST) begin
                    level <= raw;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_set_core.sv
// clock_set_core: time-of-day/calendar keeper with 1 Hz prescaler and a
// debounced 4-button set-mode FSM. Define CLOCK_ALARM_EN to add the
// hour/minute alarm compare (alarm_hour, alarm_min, alarm_arm, alarm_hit).
module clock_set_core #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int BLINK_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
`ifdef CLOCK_ALARM_EN
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm_hit,
`endif
    output logic       tick_1hz,
    output logic [7:0] year,
    output logic [7:0] month,
    output logic [7:0] day,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       set_mode,
    output logic [2:0] field_sel,
    output logic       blink
);
    import clock_pkg::*;

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam int            BLINK_PER  = (CLK_HZ / BLINK_DIV > 0) ? CLK_HZ / BLINK_DIV : 1;
    localparam int            BW         = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PER - 1);

    state_t        state, state_nxt;
    cal_t          cur, nxt;
    logic [3:0]    press;
    logic [3:0]    level_unused;
    logic [PW-1:0] presc;
    logic [BW-1:0] bcnt;
    logic [7:0]    dim_cur;

    for (genvar i = 0; i < 4; i++) begin : g_db
        sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_in[i]),
            .level (level_unused[i]),
            .press (press[i])
        );
    end

    assign dim_cur   = days_in_month(cur.month, cur.year);
    assign tick_1hz  = !rst && (state == RUN) && (presc == PRESC_LAST);
    assign field_sel = state;
    assign {year, month, day, hour, minute, second} = cur;

    // Next state: mode toggles RUN/set, next cycles fields; mode outranks next.
    always_comb begin
        // NOTE: defaulting every combinational output first keeps all paths assigned, so no latch is inferred.
        state_nxt = state;
        if (press[0]) begin
            state_nxt = (state == RUN) ? S_YEAR : RUN;
        end else if (press[1]) begin
            case (state)
                S_YEAR:  state_nxt = S_MONTH;
                S_MONTH: state_nxt = S_DAY;
                S_DAY:   state_nxt = S_HOUR;
                S_HOUR:  state_nxt = S_MIN;
                S_MIN:   state_nxt = S_SEC;
                S_SEC:   state_nxt = S_YEAR;
                default: state_nxt = state;
            endcase
        end
    end

    // Next calendar value: full carry chain on a tick, single-field inc/dec in set mode, then day clamp.
    always_comb begin
        nxt = cur;
        if (tick_1hz) begin
            nxt.second = step_wrap(cur.second, 8'd0, SEC_MAX, 1'b1);
            if (cur.second == SEC_MAX) begin
                nxt.minute = step_wrap(cur.minute, 8'd0, MIN_MAX, 1'b1);
                if (cur.minute == MIN_MAX) begin
                    nxt.hour = step_wrap(cur.hour, 8'd0, HOUR_MAX, 1'b1);
                    if (cur.hour == HOUR_MAX) begin
                        nxt.day = step_wrap(cur.day, 8'd1, dim_cur, 1'b1);
                        if (cur.day == dim_cur) begin
                            nxt.month = step_wrap(cur.month, 8'd1, MONTH_MAX, 1'b1);
                            if (cur.month == MONTH_MAX)
                                nxt.year = step_wrap(cur.year, 8'd0, YEAR_MAX, 1'b1);
                        end
                    end
                end
            end
        end else if (state != RUN && !press[0] && !press[1] && (press[2] || press[3])) begin
            // inc outranks dec, so press[2] alone decides the direction.
            case (state)
                S_YEAR:  nxt.year   = step_wrap(cur.year,   8'd0, YEAR_MAX,  press[2]);
                S_MONTH: nxt.month  = step_wrap(cur.month,  8'd1, MONTH_MAX, press[2]);
                S_DAY:   nxt.day    = step_wrap(cur.day,    8'd1, dim_cur,   press[2]);
                S_HOUR:  nxt.hour   = step_wrap(cur.hour,   8'd0, HOUR_MAX,  press[2]);
                S_MIN:   nxt.minute = step_wrap(cur.minute, 8'd0, MIN_MAX,   press[2]);
                S_SEC:   nxt.second = step_wrap(cur.second, 8'd0, SEC_MAX,   press[2]);
                default: nxt = cur;
            endcase
        end
        // Only a month/year change can leave day beyond the month's length.
        if (nxt.day > days_in_month(nxt.month, nxt.year))
            nxt.day = days_in_month(nxt.month, nxt.year);
    end

    // State register plus registered set_mode flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            set_mode <= 1'b0;
        end else begin
            state    <= state_nxt;
            set_mode <= (state_nxt != RUN);
        end
    end

    // Calendar registers.
    always_ff @(posedge clk) begin
        if (rst) cur <= '{year: 8'd0, month: 8'd1, day: 8'd1, hour: 8'd0, minute: 8'd0, second: 8'd0};
        else     cur <= nxt;
    end

    // Prescaler: free-runs only while staying in RUN, so re-entry restarts a full second.
    always_ff @(posedge clk) begin
        if (rst || state != RUN || state_nxt != RUN) presc <= '0;
        else if (presc == PRESC_LAST)                presc <= '0;
        else                                         presc <= presc + 1'b1;
    end

    // Blink divider: idle and low in RUN, restarted on entry to S_YEAR.
    always_ff @(posedge clk) begin
        if (rst || state_nxt == RUN) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (state_nxt == S_YEAR && state != S_YEAR) begin
            bcnt <= '0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            blink <= ~blink;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

`ifdef CLOCK_ALARM_EN
    // Alarm compares the post-increment time, so it fires with the tick that reaches hh:mm:00.
    assign alarm_hit = tick_1hz && alarm_arm && (nxt.hour == alarm_hour) &&
                       (nxt.minute == alarm_min) && (nxt.second == 8'd0);
`endif

endmodule

// File: tb/tb_clock_set_core.sv
// tb_clock_set_core: directed, scoreboard-checked bench for clock_set_core
// (CLK_HZ=10, DEBOUNCE_CYC=2). Alarm checks are built when CLOCK_ALARM_EN is defined.
module tb_clock_set_core;

    localparam int CLK_HZ       = 10;
    localparam int DEBOUNCE_CYC = 2;
    localparam int BLINK_DIV    = 2;

    localparam logic [3:0] BTN_MODE = 4'b0001;
    localparam logic [3:0] BTN_NEXT = 4'b0010;
    localparam logic [3:0] BTN_INC  = 4'b0100;
    localparam logic [3:0] BTN_DEC  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic       tick_1hz, set_mode, blink;
    logic [7:0] year, month, day, hour, minute, second;
    logic [2:0] field_sel;
`ifdef CLOCK_ALARM_EN
    logic [7:0] alarm_hour, alarm_min;
    logic       alarm_arm, alarm_hit;
    logic       alarm_seen;
`endif

    clock_set_core #(
        .CLK_HZ       (CLK_HZ),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
`ifdef CLOCK_ALARM_EN
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_arm  (alarm_arm),
        .alarm_hit  (alarm_hit),
`endif
        .tick_1hz   (tick_1hz),
        .year       (year),
        .month      (month),
        .day        (day),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .set_mode   (set_mode),
        .field_sel  (field_sel),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [47:0] cal;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cal(input string tag, input int y, mo, d, h, mi, s);
        exp_t e;
        e.tag = tag;
        e.cal = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
        sb_q.push_back(e);
    endtask

    // Compare every pending expectation against the calendar outputs now.
    task automatic check_cal();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, {16'd0, year, month, day, hour, minute, second}, {16'd0, e.cal});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a button mask long enough to be accepted and acted on, then release it cleanly.
    task automatic push_btn(input logic [3:0] mask);
        @(negedge clk);
        sw_in = mask;
        cycles(DEBOUNCE_CYC + 3);
        sw_in = 4'b0000;
        cycles(DEBOUNCE_CYC + 3);
    endtask

    task automatic push_n(input logic [3:0] mask, input int n);
        repeat (n) push_btn(mask);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a tick, record its cycle, then step to the post-update sample point.
    task automatic wait_tick(input string tag, output int at_cyc);
        int n = 0;
        while (tick_1hz !== 1'b1 && n < 3 * CLK_HZ) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tick_seen"}, 64'(tick_1hz), 64'd1);
        at_cyc = cyc;
`ifdef CLOCK_ALARM_EN
        alarm_seen = alarm_hit;
`endif
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1, t2;
        int ticks, changes;
        logic prev_blink;

        rst   = 1'b1;
        sw_in = 4'b0000;
`ifdef CLOCK_ALARM_EN
        alarm_hour = 8'd0;
        alarm_min  = 8'd0;
        alarm_arm  = 1'b0;
        alarm_seen = 1'b0;
`endif
        cycles(3);
        rst = 1'b0;

        // Reset state
        expect_cal("reset_cal", 0, 1, 1, 0, 0, 0);
        check_cal();
        check("reset_field_sel", 64'(field_sel), 64'd7);
        check("reset_set_mode", 64'(set_mode), 64'd0);
        check("reset_blink", 64'(blink), 64'd0);
        check("reset_tick", 64'(tick_1hz), 64'd0);

        // Rollover: preset 99-12-31 23:59:58 then two ticks
        push_btn(BTN_MODE);
        check("enter_set_field", 64'(field_sel), 64'd0);
        check("enter_set_mode", 64'(set_mode), 64'd1);
        push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_n(BTN_DEC, 2);
        check("sec_field_sel", 64'(field_sel), 64'd5);
        push_btn(BTN_MODE);
        expect_cal("preset_rollover", 99, 12, 31, 23, 59, 58);
        check_cal();
        check("run_field_sel", 64'(field_sel), 64'd7);
        check("run_set_mode", 64'(set_mode), 64'd0);
        wait_tick("roll1", t1);
        expect_cal("roll_tick1", 99, 12, 31, 23, 59, 59);
        check_cal();
        wait_tick("roll2", t2);
        expect_cal("roll_tick2", 0, 1, 1, 0, 0, 0);
        check_cal();
        check("tick_period", 64'(t2 - t1), 64'(CLK_HZ));

        // Leap year: 04-02-28 23:59:59 -> 29th
        do_reset();
        push_btn(BTN_MODE);
        push_n(BTN_INC, 4);
        push_btn(BTN_NEXT); push_btn(BTN_INC);
        push_btn(BTN_NEXT); push_n(BTN_DEC, 2);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_MODE);
        expect_cal("leap_preset", 4, 2, 28, 23, 59, 59);
        check_cal();
        wait_tick("leap", t1);
        expect_cal("leap_feb29", 4, 2, 29, 0, 0, 0);
        check_cal();

        // Year 5: Feb 29 clamps to 28, then 23:59:59 rolls into March
        push_btn(BTN_MODE);
        push_btn(BTN_INC);
        expect_cal("year_clamp", 5, 2, 28, 0, 0, 0);
        check_cal();
        push_btn(BTN_NEXT); push_btn(BTN_NEXT);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_NEXT); push_btn(BTN_DEC);
        push_btn(BTN_MODE);
        wait_tick("nonleap", t1);
        expect_cal("nonleap_mar1", 5, 3, 1, 0, 0, 0);
        check_cal();

        // Clamp: day 31 in January, then month inc twice
        do_reset();
        push_btn(BTN_MODE);
        push_btn(BTN_NEXT); push_btn(BTN_NEXT);
        push_btn(BTN_DEC);
        expect_cal("day_dec_wrap", 0, 1, 31, 0, 0, 0);
        check_cal();
        push_n(BTN_NEXT, 5);
        check("cyclic_next", 64'(field_sel), 64'd1);
        push_btn(BTN_INC);
        expect_cal("month_clamp", 0, 2, 29, 0, 0, 0);
        check_cal();
        push_btn(BTN_INC);
        expect_cal("month_no_clamp", 0, 3, 29, 0, 0, 0);
        check_cal();

        // Debounce: a short glitch is ignored, a long hold gives one increment
        @(negedge clk);
        sw_in = BTN_INC;
        cycles(DEBOUNCE_CYC - 1);
        sw_in = 4'b0000;
        cycles(8);
        expect_cal("glitch_ignored", 0, 3, 29, 0, 0, 0);
        check_cal();
        sw_in = BTN_INC;
        cycles(20);
        sw_in = 4'b0000;
        cycles(DEBOUNCE_CYC + 4);
        expect_cal("hold_one_inc", 0, 4, 29, 0, 0, 0);
        check_cal();

        // Priority: mode + inc together in S_MIN returns to RUN, minute untouched
        push_n(BTN_NEXT, 3);
        check("at_s_min", 64'(field_sel), 64'd4);
        push_btn(BTN_MODE | BTN_INC);
        check("prio_field_sel", 64'(field_sel), 64'd7);
        check("prio_set_mode", 64'(set_mode), 64'd0);
        expect_cal("prio_minute", 0, 4, 29, 0, 0, 0);
        check_cal();

        // Set mode freezes time and blinks; reset in S_HOUR restores everything
        do_reset();
        push_btn(BTN_MODE);
        push_n(BTN_NEXT, 3);
        push_btn(BTN_INC);
        expect_cal("hour_inc", 0, 1, 1, 1, 0, 0);
        check_cal();
        ticks      = 0;
        changes    = 0;
        prev_blink = blink;
        for (int i = 0; i < 2 * CLK_HZ; i++) begin
            @(negedge clk);
            if (tick_1hz === 1'b1) ticks++;
            if (blink !== prev_blink) changes++;
            prev_blink = blink;
        end
        check("set_no_tick", 64'(ticks), 64'd0);
        check("blink_toggles", 64'(changes >= 3), 64'd1);
        expect_cal("set_frozen", 0, 1, 1, 1, 0, 0);
        check_cal();
        rst = 1'b1;
        @(negedge clk);
        expect_cal("mid_set_reset", 0, 1, 1, 0, 0, 0);
        check_cal();
        check("mid_reset_field_sel", 64'(field_sel), 64'd7);
        check("mid_reset_set_mode", 64'(set_mode), 64'd0);
        check("mid_reset_blink", 64'(blink), 64'd0);
        rst = 1'b0;

`ifdef CLOCK_ALARM_EN
        // Alarm armed at 00:01, start 00:00:59
        do_reset();
        alarm_hour = 8'd0;
        alarm_min  = 8'd1;
        alarm_arm  = 1'b1;
        push_btn(BTN_MODE);
        push_n(BTN_NEXT, 5);
        push_btn(BTN_DEC);
        push_btn(BTN_MODE);
        wait_tick("alarm1", t1);
        check("alarm_hit_on_match", 64'(alarm_seen), 64'd1);
        expect_cal("alarm_time", 0, 1, 1, 0, 1, 0);
        check_cal();
        wait_tick("alarm2", t1);
        check("alarm_single_pulse", 64'(alarm_seen), 64'd0);

        // Same match with alarm disarmed
        do_reset();
        alarm_arm = 1'b0;
        push_btn(BTN_MODE);
        push_n(BTN_NEXT, 5);
        push_btn(BTN_DEC);
        push_btn(BTN_MODE);
        wait_tick("alarm3", t1);
        check("alarm_disarmed", 64'(alarm_seen), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
